// File: rtl/off_delay_timer.sv
// Off-delay (TOF) timer. DN rises one clock after the rung enable rises.
// DN falls only after en has stayed low for preset_q timebase ticks.
// All outputs are registered. The timebase comes in as one-clock tick pulses.
module off_delay_timer #(
    parameter int PRESET_W = 8,
    parameter int ACC_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                tb,
    input  logic                tick1,
    input  logic                tick2,
    input  logic [PRESET_W-1:0] preset,
    output logic                DN,
    output logic                TT,
    output logic [ACC_W-1:0]    ACC,
    output logic                expired
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        TIMING = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                dn_q, dn_d;
    logic                tt_q, tt_d;
    logic                exp_q, exp_d;
    logic [PRESET_W-1:0] preset_q, preset_d;

    logic             tick;
    logic [ACC_W-1:0] acc_inc;
    logic [ACC_W-1:0] preset_ext;

    // Timebase select: the choice of tick source is applied at the next edge.
    assign tick       = tb ? tick1 : tick2;
    assign acc_inc    = acc_q + 1'b1;
    assign preset_ext = ACC_W'(preset_q);

    // State and output registers; async reset puts the timer back to a quiet IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            dn_q     <= 1'b0;
            tt_q     <= 1'b0;
            exp_q    <= 1'b0;
            preset_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            dn_q     <= dn_d;
            tt_q     <= tt_d;
            exp_q    <= exp_d;
            preset_q <= preset_d;
        end
    end

    // Next-state and next-output logic; expired defaults low so it lasts one cycle.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        dn_d     = dn_q;
        tt_d     = tt_q;
        exp_d    = 1'b0;
        preset_d = preset_q;

        case (state_q)
            IDLE: begin
                dn_d = 1'b0;
                tt_d = 1'b0;
                if (en) begin
                    state_d = HOLD;
                    acc_d   = '0;
                    dn_d    = 1'b1;
                end
            end

            HOLD: begin
                dn_d  = 1'b1;
                tt_d  = 1'b0;
                acc_d = '0;
                if (!en) begin
                    if (preset != '0) begin
                        // Start timing. A tick in this same cycle is not counted.
                        state_d  = TIMING;
                        preset_d = preset;
                        tt_d     = 1'b1;
                    end else begin
                        // Zero preset releases at once and never shows TT.
                        state_d = IDLE;
                        dn_d    = 1'b0;
                        exp_d   = 1'b1;
                    end
                end
            end

            TIMING: begin
                dn_d = 1'b1;
                tt_d = 1'b1;
                if (en) begin
                    // Retrigger wins over a tick in the same cycle.
                    state_d = HOLD;
                    acc_d   = '0;
                    tt_d    = 1'b0;
                end else if (tick) begin
                    if (acc_inc == preset_ext) begin
                        state_d = IDLE;
                        acc_d   = preset_ext;
                        dn_d    = 1'b0;
                        tt_d    = 1'b0;
                        exp_d   = 1'b1;
                    end else begin
                        acc_d = acc_inc;
                    end
                end
            end

            default: begin
                // The unused encoding falls back to IDLE.
                state_d = IDLE;
                acc_d   = '0;
                dn_d    = 1'b0;
                tt_d    = 1'b0;
            end
        endcase
    end

    assign DN      = dn_q;
    assign TT      = tt_q;
    assign ACC     = acc_q;
    assign expired = exp_q;

endmodule

// File: tb/tb_off_delay_timer.sv
// Directed bench for off_delay_timer. Every expected value is worked out by hand.
module tb_off_delay_timer;

    logic       clk;
    logic       reset;
    logic       en;
    logic       tb;
    logic       tick1;
    logic       tick2;
    logic [7:0] preset;
    logic       DN;
    logic       TT;
    logic [7:0] ACC;
    logic       expired;

    int checks   = 0;
    int failures = 0;

    off_delay_timer #(.PRESET_W(8), .ACC_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .tb      (tb),
        .tick1   (tick1),
        .tick2   (tick2),
        .preset  (preset),
        .DN      (DN),
        .TT      (TT),
        .ACC     (ACC),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log a mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle just after it so outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one timebase pulse on the selected tick input, lasting one edge.
    task automatic pulse(input logic use1);
        if (use1) tick1 = 1'b1; else tick2 = 1'b1;
        step();
        tick1 = 1'b0;
        tick2 = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic dn, input logic tt,
                           input logic [7:0] acc, input logic ex);
        chk({tag, ".DN"},  {31'd0, DN},      {31'd0, dn});
        chk({tag, ".TT"},  {31'd0, TT},      {31'd0, tt});
        chk({tag, ".ACC"}, {24'd0, ACC},     {24'd0, acc});
        chk({tag, ".EXP"}, {31'd0, expired}, {31'd0, ex});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; tb = 1'b1; tick1 = 1'b0; tick2 = 1'b0; preset = 8'd0;
        step(); step();
        reset = 1'b0;
        step();
        // 1: reset state, then an enable with ticks present
        chk_out("rst", 1'b0, 1'b0, 8'd0, 1'b0);
        en = 1'b1;
        step();
        chk_out("en_rise", 1'b1, 1'b0, 8'd0, 1'b0);
        pulse(1'b1);
        pulse(1'b1);
        chk_out("hold_ticks", 1'b1, 1'b0, 8'd0, 1'b0);

        // 2: preset 5 on tick1; DN drops on the 5th tick
        preset = 8'd5; en = 1'b0;
        step();
        chk_out("t2_start", 1'b1, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            pulse(1'b1);
            chk_out($sformatf("t2_acc%0d", i), 1'b1, 1'b1, 8'(i), 1'b0);
        end
        pulse(1'b1);
        chk_out("t2_expire", 1'b0, 1'b0, 8'd5, 1'b1);
        step();
        chk_out("t2_after", 1'b0, 1'b0, 8'd5, 1'b0);

        // 3: retrigger with a tick in the same cycle, then a full run
        en = 1'b1; step();
        en = 1'b0; step();
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        chk_out("t3_acc3", 1'b1, 1'b1, 8'd3, 1'b0);
        en = 1'b1; tick1 = 1'b1;
        step();
        tick1 = 1'b0;
        chk_out("t3_retrig", 1'b1, 1'b0, 8'd0, 1'b0);
        en = 1'b0; tick1 = 1'b1;        // tick in the HOLD->TIMING cycle is not counted
        step();
        tick1 = 1'b0;
        chk_out("t3_start", 1'b1, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) pulse(1'b1);
        chk_out("t3_acc4", 1'b1, 1'b1, 8'd4, 1'b0);
        pulse(1'b1);
        chk_out("t3_expire", 1'b0, 1'b0, 8'd5, 1'b1);

        // 4: zero preset releases immediately without TT
        preset = 8'd0; en = 1'b1; step();
        chk_out("t4_hold", 1'b1, 1'b0, 8'd0, 1'b0);
        en = 1'b0; step();
        chk_out("t4_expire", 1'b0, 1'b0, 8'd0, 1'b1);
        step();
        chk_out("t4_after", 1'b0, 1'b0, 8'd0, 1'b0);

        // 5: tick2 timebase; tick1 ignored; preset change mid-timing ignored
        preset = 8'd4; tb = 1'b0; en = 1'b1; step();
        en = 1'b0; step();
        pulse(1'b1);
        chk_out("t5_tick1_ign", 1'b1, 1'b1, 8'd0, 1'b0);
        pulse(1'b0);
        chk_out("t5_acc1", 1'b1, 1'b1, 8'd1, 1'b0);
        preset = 8'd2;
        pulse(1'b0);
        chk_out("t5_acc2", 1'b1, 1'b1, 8'd2, 1'b0);
        pulse(1'b0);
        chk_out("t5_acc3", 1'b1, 1'b1, 8'd3, 1'b0);
        pulse(1'b0);
        chk_out("t5_expire", 1'b0, 1'b0, 8'd4, 1'b1);

        // 6: asynchronous reset in the middle of timing
        preset = 8'd5; tb = 1'b1; en = 1'b1; step();
        en = 1'b0; step();
        pulse(1'b1); pulse(1'b1); pulse(1'b1);
        chk_out("t6_acc3", 1'b1, 1'b1, 8'd3, 1'b0);
        reset = 1'b1;
        #1;
        chk_out("t6_async", 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        reset = 1'b0;
        step();
        pulse(1'b1);
        chk_out("t6_idle", 1'b0, 1'b0, 8'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
